station_operand_set: RTL and testbench
======================================

Name: station_operand_set

Overview:
- Multi-operand reservation-station entry. Holds OPERAND_COUNT source operands for one instruction.
- Each operand is either preloaded from the register file or tagged with a producing station index.
- Snoops BUS_COUNT result buses until every operand is captured, then presents ready to the issue selector.
- Compared with a single-operand slot it adds:
  - an explicit occupancy FSM (allocate/issue/flush);
  - same-cycle bus bypass at allocation;
  - a combined ready flag.

Parameters:
- SIZE, 32, operand value width in bits.
- STATION_INDEX_SIZE, 2, width of station tag.
- BUS_COUNT, 2, number of result broadcast buses.
- OPERAND_COUNT, 2, number of operands per entry.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- allocate  input  1  load new instruction operands; honoured only when free=1.
- preload_value  input  OPERAND_COUNT  bit k=1: operand k taken from preloaded_value.
- preloaded_value  input  OPERAND_COUNT*SIZE  operand k at bits [k*SIZE +: SIZE].
- source_index  input  OPERAND_COUNT*STATION_INDEX_SIZE  producing-station tag for operand k.
- issue  input  1  issue selector consumes entry; honoured only when ready=1.
- flush  input  1  discard entry (mispredict/exception).
- bus_asserted  input  BUS_COUNT  bus b carries a valid result.
- bus_source  input  BUS_COUNT*STATION_INDEX_SIZE  tag of bus b.
- bus_value  input  BUS_COUNT*SIZE  value of bus b.
- free  output  1  entry EMPTY (combinational from state).
- occupied  output  1  entry WAITING or READY.
- loaded  output  OPERAND_COUNT  operand k captured.
- value  output  OPERAND_COUNT*SIZE  captured operand values.
- ready  output  1  occupied and all loaded bits set.

Behaviour:
- Reset values: state EMPTY, loaded=0, value=0, saved tags=0. So free=1, occupied=0, ready=0.
- Bus match per operand k: lowest b with bus_asserted[b] && bus_source[b]==tag wins; higher buses are ignored.
  - At allocation, tag = the incoming source_index.
  - Afterwards, tag = the saved tag.
- States:
  - EMPTY -> WAITING on allocate. Allocate is ignored in any other state, with no effect on registers.
  - WAITING -> READY when loaded becomes all-ones.
  - READY -> EMPTY on issue.
  - Any non-EMPTY state -> EMPTY on flush.
- Flush priority: flush beats allocate, issue and bus capture in the same cycle. Flush in EMPTY has no effect.
- Allocate cycle, operand k:
  - preload=1: loaded[k]<=1, value<=preloaded_value k.
  - Else, if a bus matches source_index k this cycle (bypass): loaded[k]<=1, value<=bus value.
  - Else: loaded[k]<=0, tag k<=source_index k.
- WAITING, per cycle, operand k with loaded[k]=0 and a bus match on its saved tag: loaded[k]<=1, value k<=bus value. Operands are independent; several may capture in one cycle.
- Loaded operands never change until the next allocate. Later matching broadcasts are ignored.
- ready is combinational: occupied && &loaded.
  - Latency: allocate with all operands preloaded or bypassed gives ready=1 the next cycle.
  - A bus capture in cycle N gives ready in cycle N+1.
- state is registered and tracks ready: it moves to READY in the same edge that sets the final loaded bit.
- Issue in READY: next cycle EMPTY, loaded<=0. value holds its last contents (don't-care to consumers).
  - Issue while not ready is ignored.
- Issue and allocate in the same cycle: issue takes effect; allocate is ignored because free=0. Back-to-back reuse costs one bubble cycle.
- Reset mid-operation returns to reset values at the next edge. Pending captures are lost.

Test Plan:
- Reset, then allocate with preload=2'b11, operands 0x11/0x22 -> next cycle occupied=1, loaded=2'b11, value=0x22_0x11 (operand 1 in the upper SIZE bits), ready=1; issue -> free=1 the following cycle.
- Allocate, operand 0 preloaded 0x5, operand 1 tag 2; two cycles later bus1 asserts src=2, val=0xABCD -> loaded=2'b11, value1=0xABCD, ready=1 the cycle after the bus pulse.
- Allocate, operand 1 tag 3, while bus0 carries src=3, val=0x77 in that same cycle -> operand 1 loaded=1, value 0x77 immediately (bypass).
- Both buses assert src=1 (bus0 0x10, bus1 0x20) for an operand waiting on tag 1 -> captures 0x10. A later src=1 broadcast of 0x99 leaves 0x10 held.
- WAITING entry receives flush and a matching bus in the same cycle -> next cycle free=1, loaded=0. Allocate while WAITING -> ignored; saved tags unchanged.
- Reset asserted while WAITING with one operand loaded -> next cycle free=1, loaded=0, value=0.

Source files
------------

// File: rtl/station_operand_set.sv
// Reservation-station entry holding OPERAND_COUNT source operands that are
// either preloaded at allocation or captured later from the result buses.
module station_operand_set #(
  parameter int SIZE               = 32,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 2,
  parameter int OPERAND_COUNT      = 2
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       allocate,
  input  logic [OPERAND_COUNT-1:0]                   preload_value,
  input  logic [OPERAND_COUNT*SIZE-1:0]              preloaded_value,
  input  logic [OPERAND_COUNT*STATION_INDEX_SIZE-1:0] source_index,
  input  logic                                       issue,
  input  logic                                       flush,
  input  logic [BUS_COUNT-1:0]                       bus_asserted,
  input  logic [BUS_COUNT*STATION_INDEX_SIZE-1:0]    bus_source,
  input  logic [BUS_COUNT*SIZE-1:0]                  bus_value,
  output logic                                       free,
  output logic                                       occupied,
  output logic [OPERAND_COUNT-1:0]                   loaded,
  output logic [OPERAND_COUNT*SIZE-1:0]              value,
  output logic                                       ready,
  output logic [1:0]                                 state_debug
);

  localparam int TW = STATION_INDEX_SIZE;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAITING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                          state;
  logic [OPERAND_COUNT*TW-1:0]     saved_tag;
  logic [OPERAND_COUNT-1:0]        hit;
  logic [OPERAND_COUNT*SIZE-1:0]   hit_value;
  logic [TW-1:0]                   tag_sel;
  logic [OPERAND_COUNT-1:0]        alloc_loaded;
  logic [OPERAND_COUNT-1:0]        wait_loaded;

  assign free        = (state == EMPTY);
  assign occupied    = (state == WAITING) || (state == READY);
  assign ready       = occupied && (&loaded);
  assign state_debug = state;

  // Bus match per operand: buses scanned high to low so the lowest index wins.
  // While EMPTY the incoming tag is compared, giving same-cycle bypass.
  always_comb begin
    hit       = '0;
    hit_value = '0;
    tag_sel   = '0;
    for (int k = 0; k < OPERAND_COUNT; k++) begin
      tag_sel = (state == EMPTY) ? source_index[k*TW +: TW] : saved_tag[k*TW +: TW];
      for (int b = BUS_COUNT - 1; b >= 0; b--) begin
        if (bus_asserted[b] && (bus_source[b*TW +: TW] == tag_sel)) begin
          hit[k]                     = 1'b1;
          hit_value[k*SIZE +: SIZE]  = bus_value[b*SIZE +: SIZE];
        end
      end
    end
  end

  assign alloc_loaded = preload_value | hit;
  assign wait_loaded  = loaded | hit;

  // Handshake: allocate is accepted only when free=1, issue only when ready=1;
  // flush overrides both and any bus capture in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      loaded    <= '0;
      value     <= '0;
      saved_tag <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (allocate && !flush) begin
            for (int k = 0; k < OPERAND_COUNT; k++) begin
              if (preload_value[k]) begin
                loaded[k]              <= 1'b1;
                value[k*SIZE +: SIZE]  <= preloaded_value[k*SIZE +: SIZE];
              end else if (hit[k]) begin
                loaded[k]              <= 1'b1;
                value[k*SIZE +: SIZE]  <= hit_value[k*SIZE +: SIZE];
              end else begin
                loaded[k]              <= 1'b0;
                saved_tag[k*TW +: TW]  <= source_index[k*TW +: TW];
              end
            end
            state <= (&alloc_loaded) ? READY : WAITING;
          end
        end
        WAITING: begin
          if (flush) begin
            state  <= EMPTY;
            loaded <= '0;
          end else begin
            for (int k = 0; k < OPERAND_COUNT; k++) begin
              if (!loaded[k] && hit[k]) begin
                loaded[k]             <= 1'b1;
                value[k*SIZE +: SIZE] <= hit_value[k*SIZE +: SIZE];
              end
            end
            if (&wait_loaded) state <= READY;
          end
        end
        READY: begin
          if (flush || issue) begin
            state  <= EMPTY;
            loaded <= '0;
          end
        end
        default: begin
          state  <= EMPTY;
          loaded <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_station_operand_set.sv
// Directed bench for station_operand_set: hand-computed expectations for
// preload, bus capture, bypass, bus priority, flush, issue and reset.
module tb_station_operand_set;

  logic        clock;
  logic        reset;
  logic        allocate;
  logic [1:0]  preload_value;
  logic [63:0] preloaded_value;
  logic [3:0]  source_index;
  logic        issue;
  logic        flush;
  logic [1:0]  bus_asserted;
  logic [3:0]  bus_source;
  logic [63:0] bus_value;
  logic        free;
  logic        occupied;
  logic [1:0]  loaded;
  logic [63:0] value;
  logic        ready;
  logic [1:0]  state_debug;

  int compared;
  int mismatched;

  station_operand_set dut (
    .clock           (clock),
    .reset           (reset),
    .allocate        (allocate),
    .preload_value   (preload_value),
    .preloaded_value (preloaded_value),
    .source_index    (source_index),
    .issue           (issue),
    .flush           (flush),
    .bus_asserted    (bus_asserted),
    .bus_source      (bus_source),
    .bus_value       (bus_value),
    .free            (free),
    .occupied        (occupied),
    .loaded          (loaded),
    .value           (value),
    .ready           (ready),
    .state_debug     (state_debug)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    allocate        = 1'b0;
    preload_value   = 2'b00;
    preloaded_value = '0;
    source_index    = '0;
    issue           = 1'b0;
    flush           = 1'b0;
    bus_asserted    = 2'b00;
    bus_source      = '0;
    bus_value       = '0;
  endtask

  task automatic drive_alloc(input logic [1:0] pre, input logic [31:0] v1, input logic [31:0] v0,
                             input logic [1:0] t1, input logic [1:0] t0);
    allocate        = 1'b1;
    preload_value   = pre;
    preloaded_value = {v1, v0};
    source_index    = {t1, t0};
  endtask

  task automatic drive_bus(input logic [1:0] asrt, input logic [1:0] s1, input logic [31:0] v1,
                           input logic [1:0] s0, input logic [31:0] v0);
    bus_asserted = asrt;
    bus_source   = {s1, s0};
    bus_value    = {v1, v0};
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_free", free, 1);
    check_eq("rst_occupied", occupied, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_loaded", loaded, 0);
    check_eq("rst_value", value, 0);
    check_eq("rst_state", state_debug, 0);

    // Both operands preloaded -> ready next cycle, issue frees it.
    drive_alloc(2'b11, 32'h22, 32'h11, 2'd0, 2'd0);
    tick();
    idle();
    check_eq("pre_occupied", occupied, 1);
    check_eq("pre_loaded", loaded, 2'b11);
    check_eq("pre_value", value, 64'h00000022_00000011);
    check_eq("pre_ready", ready, 1);
    check_eq("pre_state", state_debug, 2);
    issue = 1'b1;
    tick();
    idle();
    check_eq("issue_free", free, 1);
    check_eq("issue_loaded", loaded, 0);

    // Operand 0 preloaded, operand 1 waits on tag 2; capture from bus1.
    drive_alloc(2'b01, 32'h0, 32'h5, 2'd2, 2'd0);
    tick();
    idle();
    check_eq("wait_loaded", loaded, 2'b01);
    check_eq("wait_ready", ready, 0);
    check_eq("wait_state", state_debug, 1);
    drive_bus(2'b00, 2'd2, 32'hDEAD, 2'd2, 32'hBEEF);
    tick();
    idle();
    check_eq("unasserted_bus", loaded, 2'b01);
    drive_bus(2'b10, 2'd2, 32'hABCD, 2'd0, 32'h0);
    check_eq("ready_during_pulse", ready, 0);
    tick();
    idle();
    check_eq("cap_loaded", loaded, 2'b11);
    check_eq("cap_value", value, 64'h0000ABCD_00000005);
    check_eq("cap_ready", ready, 1);
    flush = 1'b1;
    tick();
    idle();
    check_eq("flush_ready_free", free, 1);

    // Bypass at allocation: bus0 carries tag 3 in the allocate cycle.
    drive_alloc(2'b01, 32'h0, 32'h1, 2'd3, 2'd0);
    drive_bus(2'b01, 2'd0, 32'h0, 2'd3, 32'h77);
    tick();
    idle();
    check_eq("byp_loaded", loaded, 2'b11);
    check_eq("byp_value", value, 64'h00000077_00000001);
    check_eq("byp_ready", ready, 1);
    // Issue with allocate in same cycle: allocate ignored, one bubble.
    issue = 1'b1;
    drive_alloc(2'b11, 32'hAA, 32'hBB, 2'd0, 2'd0);
    tick();
    idle();
    check_eq("iss_alloc_free", free, 1);
    check_eq("iss_alloc_occupied", occupied, 0);

    // Flush with allocate while EMPTY: nothing happens.
    flush = 1'b1;
    drive_alloc(2'b11, 32'hAA, 32'hBB, 2'd0, 2'd0);
    tick();
    idle();
    check_eq("flush_empty_free", free, 1);

    // Bus priority and hold after capture; issue while waiting is ignored.
    drive_alloc(2'b01, 32'h0, 32'h3, 2'd1, 2'd0);
    tick();
    idle();
    issue = 1'b1;
    tick();
    idle();
    check_eq("issue_not_ready", state_debug, 1);
    drive_bus(2'b11, 2'd1, 32'h20, 2'd1, 32'h10);
    tick();
    idle();
    check_eq("prio_value", value, 64'h00000010_00000003);
    check_eq("prio_ready", ready, 1);
    drive_bus(2'b01, 2'd0, 32'h0, 2'd1, 32'h99);
    tick();
    idle();
    check_eq("hold_value", value, 64'h00000010_00000003);
    flush = 1'b1;
    tick();
    idle();

    // Two operands captured from different buses in the same cycle.
    drive_alloc(2'b00, 32'h0, 32'h0, 2'd3, 2'd2);
    tick();
    idle();
    check_eq("two_wait_loaded", loaded, 2'b00);
    drive_bus(2'b11, 2'd2, 32'hB, 2'd3, 32'hA);
    tick();
    idle();
    check_eq("two_cap_value", value, 64'h0000000A_0000000B);
    check_eq("two_cap_ready", ready, 1);
    flush = 1'b1;
    tick();
    idle();

    // Allocate while WAITING ignored, saved tags kept; flush beats bus capture.
    drive_alloc(2'b00, 32'h0, 32'h0, 2'd2, 2'd1);
    tick();
    idle();
    drive_alloc(2'b11, 32'hEE, 32'hFF, 2'd3, 2'd0);
    tick();
    idle();
    check_eq("realloc_loaded", loaded, 2'b00);
    check_eq("realloc_state", state_debug, 1);
    drive_bus(2'b01, 2'd0, 32'h0, 2'd1, 32'h44);
    tick();
    idle();
    check_eq("old_tag_loaded", loaded, 2'b01);
    check_eq("old_tag_value", value[31:0], 32'h44);
    flush = 1'b1;
    drive_bus(2'b01, 2'd0, 32'h0, 2'd2, 32'h55);
    tick();
    idle();
    check_eq("flush_bus_free", free, 1);
    check_eq("flush_bus_loaded", loaded, 0);

    // Reset while WAITING with one operand loaded.
    drive_alloc(2'b01, 32'h0, 32'h66, 2'd2, 2'd0);
    tick();
    idle();
    check_eq("pre_reset_loaded", loaded, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_free", free, 1);
    check_eq("mid_rst_loaded", loaded, 0);
    check_eq("mid_rst_value", value, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
